// File: rtl/branch_fwd_pkg.sv
// ============================================================================
// branch_fwd_pkg : shared encodings for the branch-operand forwarding controller
// Revision 1.0
// ============================================================================
`default_nettype none

package branch_fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam int MAX_STALL = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_src_match.sv
// ============================================================================
// branch_src_match : per-source producer compare giving forward select and
//                    the number of interlock cycles this source needs
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_src_match
  import branch_fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_wr_en,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  exmem_wr_en,
  input  logic                  exmem_is_load,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_wr_en,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output logic [1:0]            fwd_sel,
  output logic [1:0]            need
);

  logic src_valid;
  logic ex_hit;
  logic exmem_hit;
  logic memwb_hit;

  // r0 is hard-wired zero, so it never takes a forwarded value
  assign src_valid = (src != '0);
  assign ex_hit    = src_valid && ex_wr_en    && (ex_rd    == src);
  assign exmem_hit = src_valid && exmem_wr_en && (exmem_rd == src);
  assign memwb_hit = src_valid && memwb_wr_en && (memwb_rd == src);

  always_comb begin
    fwd_sel = FWD_RF;
    if (exmem_hit && !exmem_is_load) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      fwd_sel = FWD_MEMWB;
    end
  end

  always_comb begin
    need = 2'd0;
    if (ex_hit && ex_is_load) begin
      need = 2'd2;
    end else if (ex_hit || (exmem_hit && exmem_is_load)) begin
      need = 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_forward_ctrl.sv
// ============================================================================
// branch_forward_ctrl : ID-stage branch operand forwarding and interlock FSM
// Optional statistics counters enabled by macro BRANCH_FWD_STATS_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_forward_ctrl
  import branch_fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int CNT_W      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          id_branch,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic                          ex_wr_en,
  input  logic                          ex_is_load,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          exmem_wr_en,
  input  logic                          exmem_is_load,
  input  logic [REG_ADDR_W-1:0]         exmem_rd,
  input  logic                          memwb_wr_en,
  input  logic [REG_ADDR_W-1:0]         memwb_rd,
  input  logic                          hold,
  input  logic                          id_flush,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall,
  output logic [CNT_W-1:0]              stat_stall_cyc,
  output logic [CNT_W-1:0]              stat_fwd_exmem,
  output logic [CNT_W-1:0]              stat_fwd_memwb
);

  logic [1:0] src_sel  [NUM_SRC];
  logic [1:0] src_need [NUM_SRC];
  logic [1:0] need_max;
  state_t     state;
  logic [1:0] cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    branch_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
      .src           (id_src[i*REG_ADDR_W +: REG_ADDR_W]),
      .ex_wr_en      (ex_wr_en),
      .ex_is_load    (ex_is_load),
      .ex_rd         (ex_rd),
      .exmem_wr_en   (exmem_wr_en),
      .exmem_is_load (exmem_is_load),
      .exmem_rd      (exmem_rd),
      .memwb_wr_en   (memwb_wr_en),
      .memwb_rd      (memwb_rd),
      .fwd_sel       (src_sel[i]),
      .need          (src_need[i])
    );

    assign fwd_sel[2*i +: 2] = (id_branch && !reset) ? src_sel[i] : FWD_RF;
  end

  always_comb begin
    need_max = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_need[i] > need_max) need_max = src_need[i];
    end
    if (!id_branch) need_max = 2'd0;
  end

  // A flushed branch no longer cares about its operands, so it never stalls
  assign stall = !reset && !id_flush && ((state == ST_STALL) || (need_max != 2'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else if (id_flush) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else if (!hold) begin
      case (state)
        ST_IDLE: begin
          if (need_max == 2'(MAX_STALL)) begin
            state <= ST_STALL;
            cnt   <= 2'(MAX_STALL - 1);
          end
        end
        ST_STALL: begin
          if (cnt == 2'd1) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

`ifdef BRANCH_FWD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic any_exmem;
  logic any_memwb;

  always_comb begin
    any_exmem = 1'b0;
    any_memwb = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel[i] == FWD_EXMEM) any_exmem = 1'b1;
      if (src_sel[i] == FWD_MEMWB) any_memwb = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_stall_cyc <= '0;
      stat_fwd_exmem <= '0;
      stat_fwd_memwb <= '0;
    end else if (!hold) begin
      if (stall) stat_stall_cyc <= stat_stall_cyc + CNT_ONE;
      if (id_branch && !stall && any_exmem) stat_fwd_exmem <= stat_fwd_exmem + CNT_ONE;
      if (id_branch && !stall && any_memwb) stat_fwd_memwb <= stat_fwd_memwb + CNT_ONE;
    end
  end
`else
  assign stat_stall_cyc = '0;
  assign stat_fwd_exmem = '0;
  assign stat_fwd_memwb = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_forward_ctrl.sv
// ============================================================================
// tb_branch_forward_ctrl : directed + random check of branch_forward_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_branch_forward_ctrl;

  localparam int RW = 5;
  localparam int NS = 2;
  localparam int CW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            id_branch;
  logic [NS*RW-1:0] id_src;
  logic            ex_wr_en, ex_is_load;
  logic [RW-1:0]   ex_rd;
  logic            exmem_wr_en, exmem_is_load;
  logic [RW-1:0]   exmem_rd;
  logic            memwb_wr_en;
  logic [RW-1:0]   memwb_rd;
  logic            hold, id_flush;
  logic [2*NS-1:0] fwd_sel;
  logic            stall;
  logic [CW-1:0]   stat_stall_cyc, stat_fwd_exmem, stat_fwd_memwb;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: number of forced stall cycles still owed, plus counters
  int            owed = 0;
  logic [CW-1:0] m_stall_cyc = '0, m_exm = '0, m_mwb = '0;
  logic          last_stall;

  always #5 clock = ~clock;

  branch_forward_ctrl #(.REG_ADDR_W(RW), .NUM_SRC(NS), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .id_branch(id_branch), .id_src(id_src),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .exmem_wr_en(exmem_wr_en), .exmem_is_load(exmem_is_load), .exmem_rd(exmem_rd),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .hold(hold), .id_flush(id_flush),
    .fwd_sel(fwd_sel), .stall(stall), .stat_stall_cyc(stat_stall_cyc),
    .stat_fwd_exmem(stat_fwd_exmem), .stat_fwd_memwb(stat_fwd_memwb)
  );

  function automatic logic [1:0] ref_sel(input logic [RW-1:0] s);
    if (s == 0) return 2'b00;
    if (exmem_wr_en && exmem_rd == s && !exmem_is_load) return 2'b10;
    if (memwb_wr_en && memwb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int ref_need(input logic [RW-1:0] s);
    int n = 0;
    if (s == 0) return 0;
    if (ex_wr_en && ex_rd == s) n = ex_is_load ? 2 : 1;
    if (exmem_wr_en && exmem_rd == s && exmem_is_load && n < 1) n = 1;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    reset = 0; id_branch = 0; id_src = '0; hold = 0; id_flush = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_rd = '0;
    exmem_wr_en = 0; exmem_is_load = 0; exmem_rd = '0;
    memwb_wr_en = 0; memwb_rd = '0;
  endtask

  // one cycle: check outputs mid-cycle, then advance the model at the edge
  task automatic tick();
    logic [2*NS-1:0] e_sel;
    int   nmax;
    logic e_stall, any10, any01;
    #1;
    e_sel = '0; nmax = 0; any10 = 0; any01 = 0;
    for (int i = 0; i < NS; i++) begin
      logic [1:0] s;
      int n;
      s = ref_sel(id_src[i*RW +: RW]);
      n = ref_need(id_src[i*RW +: RW]);
      if (s == 2'b10) any10 = 1;
      if (s == 2'b01) any01 = 1;
      if (id_branch && !reset) e_sel[2*i +: 2] = s;
      if (n > nmax) nmax = n;
    end
    if (!id_branch) nmax = 0;
    e_stall = !reset && !id_flush && (owed > 0 || nmax > 0);
    check("fwd_sel", 64'(fwd_sel), 64'(e_sel));
    check("stall", 64'(stall), 64'(e_stall));
`ifdef BRANCH_FWD_STATS_EN
    check("stat_stall_cyc", 64'(stat_stall_cyc), 64'(m_stall_cyc));
    check("stat_fwd_exmem", 64'(stat_fwd_exmem), 64'(m_exm));
    check("stat_fwd_memwb", 64'(stat_fwd_memwb), 64'(m_mwb));
`else
    check("stat_zero", 64'(stat_stall_cyc | stat_fwd_exmem | stat_fwd_memwb), 64'd0);
`endif
    last_stall = stall;
    @(posedge clock);
    if (reset) begin
      owed = 0; m_stall_cyc = '0; m_exm = '0; m_mwb = '0;
    end else begin
      if (!hold) begin
        if (e_stall) m_stall_cyc = m_stall_cyc + 1;
        if (id_branch && !e_stall && any10) m_exm = m_exm + 1;
        if (id_branch && !e_stall && any01) m_mwb = m_mwb + 1;
      end
      if (id_flush) owed = 0;
      else if (!hold) owed = (owed > 0) ? owed - 1 : ((nmax > 0) ? nmax - 1 : 0);
    end
    @(negedge clock);
  endtask

  task automatic load_use(input logic [RW-1:0] r);
    clear(); id_branch = 1; id_src[2*RW-1:RW] = r;
    ex_wr_en = 1; ex_is_load = 1; ex_rd = r;
  endtask

  task automatic load_in_exmem(input logic [RW-1:0] r);
    clear(); id_branch = 1; id_src[2*RW-1:RW] = r;
    exmem_wr_en = 1; exmem_is_load = 1; exmem_rd = r;
  endtask

  initial begin
    int sc;
    clear(); reset = 1;
    @(negedge clock);
    tick();
    // reset dominates even with a would-be stall present
    load_use(5'd4); reset = 1; tick();
    clear();

    // ALU producer, then forward from EX/MEM
    id_branch = 1; id_src[RW-1:0] = 5'd5; ex_wr_en = 1; ex_rd = 5'd5; tick();
    check("alu_stall", 64'(last_stall), 64'd1);
    clear(); id_branch = 1; id_src[RW-1:0] = 5'd5; exmem_wr_en = 1; exmem_rd = 5'd5; tick();
    check("alu_fwd", 64'(last_stall), 64'd0);

    // load-use: two stall cycles, then MEM/WB forward
    load_use(5'd8); tick();
    load_in_exmem(5'd8); tick();
    clear(); id_branch = 1; id_src[2*RW-1:RW] = 5'd8; memwb_wr_en = 1; memwb_rd = 5'd8; tick();

    // EX/MEM priority over MEM/WB, and r0 never matches
    clear(); id_branch = 1; id_src[RW-1:0] = 5'd3;
    exmem_wr_en = 1; exmem_rd = 5'd3; memwb_wr_en = 1; memwb_rd = 5'd3; tick();
    clear(); id_branch = 1; ex_wr_en = 1; ex_is_load = 1; exmem_wr_en = 1;
    exmem_is_load = 1; memwb_wr_en = 1; tick();

    // hold mid-STALL stretches the load-use interlock to five cycles
    sc = 0;
    load_use(5'd9); tick(); sc += int'(last_stall);
    for (int k = 0; k < 3; k++) begin
      load_in_exmem(5'd9); hold = 1; tick(); sc += int'(last_stall);
    end
    load_in_exmem(5'd9); tick(); sc += int'(last_stall);
    check("hold_stall_total", 64'(sc), 64'd5);
    clear(); id_branch = 1; id_src[2*RW-1:RW] = 5'd9; memwb_wr_en = 1; memwb_rd = 5'd9; tick();

    // flush inside STALL
    load_use(5'd10); tick();
    load_in_exmem(5'd10); id_flush = 1; tick();
    clear(); id_branch = 1; id_src = {5'd11, 5'd12}; tick();

    // reset mid-STALL
    load_use(5'd6); tick();
    load_in_exmem(5'd6); reset = 1; tick();
    clear(); id_branch = 1; tick();

    // randomized traffic over a small register range to force overlaps
    repeat (600) begin
      reset         = ($urandom_range(0, 99) < 2);
      hold          = ($urandom_range(0, 99) < 12);
      id_flush      = ($urandom_range(0, 99) < 6);
      id_branch     = ($urandom_range(0, 99) < 80);
      id_src        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_wr_en      = 1'($urandom);
      ex_is_load    = 1'($urandom);
      ex_rd         = 5'($urandom_range(0, 3));
      exmem_wr_en   = 1'($urandom);
      exmem_is_load = 1'($urandom);
      exmem_rd      = 5'($urandom_range(0, 3));
      memwb_wr_en   = 1'($urandom);
      memwb_rd      = 5'($urandom_range(0, 3));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
